// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   Load/store unit between the execute stage and a 64-bit data memory port.
//   Takes one request per handshake, issues a single 8-byte-aligned access,
//   lane-shifts and masks store data, shifts and extends load data, and
//   returns the result on a valid/ready response channel. Only one request
//   is ever in flight.
//
// Parameters:
//   WAIT_CYCLES   extra cycles mem_ce is held before the access completes (0..15)
//
// Ports:
//   clk, reset            clock (rising edge) / async active-high reset
//   req_valid/req_ready   request handshake
//   req_we                1 = store, 0 = load
//   req_addr              byte address
//   req_size              0 = byte, 1 = half, 2 = word, 3 = dword
//   req_unsigned          loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata             store data, right-justified
//   resp_valid/resp_ready response handshake
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_err              misaligned-access error
//   mem_addr/ce/we        memory address (dword aligned), enable, write enable
//   mem_wdata/mem_wmask   lane-shifted store data and byte-lane mask
//   mem_rdata             memory read data, combinational with mem_ce
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_addr,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [63:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic        r_err;

    logic        w_misaligned;
    logic        w_inAccess;
    logic        w_lastCycle;
    logic [63:0] w_shifted;
    logic [63:0] w_loadExt;
    logic [7:0]  w_baseMask;

    // Alignment check on the incoming request: each size must sit on its
    // natural boundary inside the dword.
    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            2'd1:    w_misaligned = req_addr[0];
            2'd2:    w_misaligned = |req_addr[1:0];
            2'd3:    w_misaligned = |req_addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    // Move the addressed bytes down to bit 0, then extend from the top bit
    // of the field (or zero-fill for unsigned loads).
    always_comb begin
        w_shifted = mem_rdata >> {r_addr[2:0], 3'b000};
        w_loadExt = w_shifted;
        case (r_size)
            2'd0: w_loadExt = r_unsigned ? {56'd0, w_shifted[7:0]}
                                         : {{56{w_shifted[7]}}, w_shifted[7:0]};
            2'd1: w_loadExt = r_unsigned ? {48'd0, w_shifted[15:0]}
                                         : {{48{w_shifted[15]}}, w_shifted[15:0]};
            2'd2: w_loadExt = r_unsigned ? {32'd0, w_shifted[31:0]}
                                         : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: w_loadExt = w_shifted;
        endcase
    end

    // Unshifted byte-lane mask for each access size.
    always_comb begin
        w_baseMask = 8'hFF;
        case (r_size)
            2'd0:    w_baseMask = 8'h01;
            2'd1:    w_baseMask = 8'h03;
            2'd2:    w_baseMask = 8'h0F;
            default: w_baseMask = 8'hFF;
        endcase
    end

    assign w_inAccess  = (r_state == ST_ACCESS);
    assign w_lastCycle = w_inAccess && (r_cnt == 4'd0);

    // Main control: latch the request in IDLE, count down the wait cycles
    // in ACCESS, and hold the response in RESP until the consumer takes it.
    // Misaligned requests skip ACCESS entirely so memory is never touched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= 64'd0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_wdata    <= 64'd0;
            r_rdata    <= 64'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_addr     <= req_addr;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_wdata    <= req_wdata;
                        r_rdata    <= 64'd0;
                        if (w_misaligned) begin
                            r_err   <= 1'b1;
                            r_state <= ST_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_cnt   <= 4'(WAIT_CYCLES);
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rdata <= r_we ? 64'd0 : w_loadExt;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // req_ready is gated by reset so it reads 0 while reset is held even
    // though the state register already sits in IDLE.
    assign req_ready  = (r_state == ST_IDLE) && !reset;
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // Memory side is only driven during ACCESS; the write strobe appears
    // in the final access cycle so a store writes exactly once.
    assign mem_ce    = w_inAccess;
    assign mem_we    = w_lastCycle && r_we;
    assign mem_addr  = w_inAccess ? {r_addr[63:3], 3'b000} : 64'd0;
    assign mem_wdata = (w_inAccess && r_we) ? (r_wdata << {r_addr[2:0], 3'b000}) : 64'd0;
    assign mem_wmask = (w_inAccess && r_we) ? (w_baseMask << r_addr[2:0]) : 8'd0;

endmodule
